// File: rtl/kolibri_pkg.sv
// Shared definitions for the SD-card SPI master: register map, status bits,
// the shift-engine state encoding and the bus sample record.
package kolibri_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;

  localparam int CTRL_SS0  = 0;
  localparam int CTRL_SS1  = 1;
  localparam int CTRL_AUTO = 2;
  localparam int STAT_OVR  = 6;
  localparam int STAT_BUSY = 7;

  localparam int DIV_RESET = 59;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} spiState_t;

  typedef struct packed {
    logic       nCs;
    logic       rw;
    logic [1:0] a;
    logic [7:0] din;
  } busSample_t;
endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI byte engine: half-period divider, bit counter, combined tx/rx
// shift register. One byte per start; start is ignored unless idle.
module spi_shift_engine
  import kolibri_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       txByte,
  input  logic [DIV_W-1:0] div,
  input  logic             miso,
  output logic             busy,
  output logic [7:0]       rxByte,
  output logic             sclk,
  output logic             mosi
);
  spiState_t        state, stateN;
  logic [DIV_W-1:0] cnt, cntN, divLat, divLatN;
  logic [2:0]       bitCnt, bitCntN;
  logic [7:0]       shReg, shRegN, rxN;
  logic             sclkN, mosiN;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      divLat <= '0;
      bitCnt <= '0;
      shReg  <= 8'hFF;
      rxByte <= 8'hFF;
      sclk   <= 1'b0;
      mosi   <= 1'b1;
    end else begin
      state  <= stateN;
      cnt    <= cntN;
      divLat <= divLatN;
      bitCnt <= bitCntN;
      shReg  <= shRegN;
      rxByte <= rxN;
      sclk   <= sclkN;
      mosi   <= mosiN;
    end
  end

  // Shift register sends from the MSB and collects MISO into the LSB, so
  // after eight rising edges it holds exactly the received byte.
  always_comb begin
    stateN  = state;
    cntN    = cnt;
    divLatN = divLat;
    bitCntN = bitCnt;
    shRegN  = shReg;
    rxN     = rxByte;
    sclkN   = sclk;
    mosiN   = mosi;
    case (state)
      IDLE: if (start) begin
        stateN  = LOW;
        divLatN = div;
        cntN    = div;
        bitCntN = '0;
        shRegN  = txByte;
        mosiN   = txByte[7];
        sclkN   = 1'b0;
      end
      LOW: if (cnt == '0) begin
        cntN   = divLat;
        stateN = HIGH;
        sclkN  = 1'b1;
        shRegN = {shReg[6:0], miso};
      end else cntN = cnt - 1'b1;
      HIGH: if (cnt == '0) begin
        cntN  = divLat;
        sclkN = 1'b0;
        if (bitCnt == 3'd7) begin
          stateN = IDLE;
          rxN    = shReg;
          mosiN  = 1'b1;
        end else begin
          stateN  = LOW;
          bitCntN = bitCnt + 1'b1;
          mosiN   = shReg[7];
        end
      end else cntN = cnt - 1'b1;
      default: stateN = IDLE;
    endcase
  end
endmodule

// File: rtl/sd_spi_ctrl.sv
// CPU register window ($FE30-$FE33) for the SD-card SPI master: nE
// synchroniser, register file, chip-select decode and read side-effects.
module sd_spi_ctrl #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = kolibri_pkg::DIV_RESET
) (
  input  logic       MHZ48,
  input  logic       RES,
  input  logic       nE,
  input  logic       nCS,
  input  logic       RW,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       nSD0,
  output logic       nSD1,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);
  import kolibri_pkg::*;

  logic             s1, s2;
  busSample_t       st1, st2;
  logic             ss0, ss1, autoRd, ovr;
  logic [DIV_W-1:0] divReg;
  logic             busy, commit, wrStart, rdStart, startReq;
  logic [7:0]       txByte, rxByte;

  // Commit on the synchronised rising edge of nE, i.e. the end of the bus
  // phase; st2 then holds the bus as sampled while nE was still low.
  always_ff @(posedge MHZ48 or posedge RES) begin
    if (RES) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      st1 <= '{nCs: 1'b1, rw: 1'b0, a: 2'b0, din: 8'h00};
      st2 <= '{nCs: 1'b1, rw: 1'b0, a: 2'b0, din: 8'h00};
    end else begin
      s1  <= nE;
      s2  <= s1;
      st1 <= '{nCs: nCS, rw: RW, a: A, din: DIN};
      st2 <= st1;
    end
  end

  always_comb begin
    commit   = s1 & ~s2 & ~st2.nCs;
    wrStart  = commit & ~st2.rw & (st2.a == REG_DATA);
    rdStart  = commit & st2.rw & (st2.a == REG_DATA) & autoRd;
    startReq = wrStart | rdStart;
    txByte   = wrStart ? st2.din : 8'hFF;
  end

  always_ff @(posedge MHZ48 or posedge RES) begin
    if (RES) begin
      ss0    <= 1'b0;
      ss1    <= 1'b0;
      autoRd <= 1'b0;
      ovr    <= 1'b0;
      divReg <= DIV_W'(DIV_RESET);
    end else begin
      if (commit & ~st2.rw & (st2.a == REG_CTRL)) begin
        ss0    <= st2.din[CTRL_SS0];
        ss1    <= st2.din[CTRL_SS1];
        autoRd <= st2.din[CTRL_AUTO];
      end
      if (commit & ~st2.rw & (st2.a == REG_DIV))
        divReg <= DIV_W'(st2.din);
      if (startReq & busy)
        ovr <= 1'b1;
      else if (commit & st2.rw & (st2.a == REG_CTRL))
        ovr <= 1'b0;
    end
  end

  spi_shift_engine #(.DIV_W(DIV_W)) engine (
    .clk    (MHZ48),
    .rst    (RES),
    .start  (startReq & ~busy),
    .txByte (txByte),
    .div    (divReg),
    .miso   (MISO),
    .busy   (busy),
    .rxByte (rxByte),
    .sclk   (SCLK),
    .mosi   (MOSI)
  );

  // SS0 wins so the two cards can never be selected together.
  assign nSD0 = ~ss0;
  assign nSD1 = ~(ss1 & ~ss0);
  assign DOE  = ~nCS & RW & ~nE;

  always_comb begin
    DOUT = 8'h00;
    case (A)
      REG_DATA: DOUT = rxByte;
      REG_CTRL: DOUT = {busy, ovr, 3'b000, autoRd, ss1, ss0};
      REG_DIV:  DOUT = 8'(divReg);
      default:  DOUT = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Bench for sd_spi_ctrl: register table, directed transfers, random
// transfers against an SPI-slave model, overrun and mid-transfer reset.
module tb_sd_spi_ctrl;
  logic       MHZ48 = 1'b0, RES = 1'b1, nE = 1'b1, nCS = 1'b1, RW = 1'b1, MISO = 1'b1;
  logic [1:0] A = 2'd0;
  logic [7:0] DIN = 8'h00, DOUT;
  logic       DOE, nSD0, nSD1, SCLK, MOSI;

  sd_spi_ctrl #(.DIV_W(8), .DIV_RESET(59)) dut (
    .MHZ48(MHZ48), .RES(RES), .nE(nE), .nCS(nCS), .RW(RW), .A(A), .DIN(DIN),
    .DOUT(DOUT), .DOE(DOE), .nSD0(nSD0), .nSD1(nSD1), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO)
  );

  always #10 MHZ48 = ~MHZ48;

  int nVec = 0, nMis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI slave model plus phase/bit recorder, evaluated mid-cycle.
  logic [7:0] misoByte = 8'hFF;
  int         misoIdx = 8, runLen = 0, busyCnt = 0;
  logic       busyPrev = 1'b0, sclkPrev = 1'b0;
  int         phaseQ[$];
  logic       mosiQ[$];

  always @(negedge MHZ48) begin
    if (dut.busy === 1'b1) begin
      if (!busyPrev) begin
        runLen  = 1;
        misoIdx = 0;
      end else if (SCLK !== sclkPrev) begin
        phaseQ.push_back(runLen);
        runLen = 1;
        if (SCLK) mosiQ.push_back(MOSI);
        else misoIdx++;
      end else runLen++;
      busyCnt++;
    end else if (busyPrev) phaseQ.push_back(runLen);
    MISO     = (misoIdx < 8) ? misoByte[3'(7 - misoIdx)] : 1'b1;
    busyPrev = dut.busy;
    sclkPrev = SCLK;
  end

  task automatic bus(input logic rw, input logic [1:0] a, input logic [7:0] d,
                     output logic [7:0] q, output logic oe);
    @(negedge MHZ48);
    nCS = 1'b0; RW = rw; A = a; DIN = d; nE = 1'b0;
    repeat (4) @(negedge MHZ48);
    q  = DOUT;
    oe = DOE;
    nE = 1'b1;
    @(negedge MHZ48);
    nCS = 1'b1; RW = 1'b1;
    repeat (3) @(negedge MHZ48);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q; logic oe;
    bus(1'b0, a, d, q, oe);
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] q; logic oe;
    bus(1'b1, a, 8'h00, q, oe);
    chk(name, q, exp);
    chk({name, " DOE"}, oe, 1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (dut.busy === 1'b1 && n < 20000) begin
      @(negedge MHZ48);
      n++;
    end
    if (n >= 20000) begin
      nVec++; nMis++;
      $display("FAIL busy timeout: still busy after %0d cycles", n);
    end
    repeat (2) @(negedge MHZ48);
  endtask

  task automatic clearRec();
    phaseQ.delete();
    mosiQ.delete();
    busyCnt = 0;
  endtask

  // Reference: MOSI carries tx MSB-first, every phase is div+1 cycles,
  // 16 phases, BUSY lasts 16*(div+1) cycles.
  task automatic checkXfer(input string tag, input int div, input logic [7:0] tx);
    logic [31:0] v = 0;
    int bad = 0;
    foreach (mosiQ[i]) v = {v[30:0], mosiQ[i]};
    foreach (phaseQ[i]) if (phaseQ[i] != div + 1) bad++;
    chk({tag, " mosi bits"}, v, {24'h0, tx});
    chk({tag, " phase count"}, phaseQ.size(), 16);
    chk({tag, " bad phases"}, bad, 0);
    chk({tag, " busy cycles"}, busyCnt, 16 * (div + 1));
  endtask

  task automatic runXfer(input string tag, input int div, input logic [7:0] tx, input logic [7:0] mi);
    wr(2'd2, 8'(div));
    misoByte = mi;
    clearRec();
    wr(2'd0, tx);
    waitIdle();
    checkXfer(tag, div, tx);
    rd({tag, " rx"}, 2'd0, mi);
  endtask

  typedef struct {
    logic       rw;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic [1:0] expSd;
  } vec_t;

  vec_t       tbl[14];
  logic [7:0] lastRx;

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'h00, 8'hFF, 2'b11};
    tbl[1]  = '{1'b1, 2'd1, 8'h00, 8'h00, 2'b11};
    tbl[2]  = '{1'b1, 2'd2, 8'h00, 8'h3B, 2'b11};
    tbl[3]  = '{1'b1, 2'd3, 8'h00, 8'h00, 2'b11};
    tbl[4]  = '{1'b0, 2'd3, 8'h55, 8'h00, 2'b11};
    tbl[5]  = '{1'b1, 2'd3, 8'h00, 8'h00, 2'b11};
    tbl[6]  = '{1'b0, 2'd2, 8'h07, 8'h00, 2'b11};
    tbl[7]  = '{1'b1, 2'd2, 8'h00, 8'h07, 2'b11};
    tbl[8]  = '{1'b0, 2'd1, 8'h03, 8'h00, 2'b10};
    tbl[9]  = '{1'b1, 2'd1, 8'h00, 8'h03, 2'b10};
    tbl[10] = '{1'b0, 2'd1, 8'h02, 8'h00, 2'b01};
    tbl[11] = '{1'b1, 2'd1, 8'h00, 8'h02, 2'b01};
    tbl[12] = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b11};
    tbl[13] = '{1'b1, 2'd1, 8'h00, 8'h00, 2'b11};

    repeat (3) @(negedge MHZ48);
    chk("reset SCLK", SCLK, 0);
    chk("reset MOSI", MOSI, 1);
    chk("reset nSD", {nSD1, nSD0}, 2'b11);
    chk("reset DOE", DOE, 0);
    RES = 1'b0;
    repeat (2) @(negedge MHZ48);

    for (int i = 0; i < 14; i++) begin
      logic [7:0] q; logic oe;
      bus(tbl[i].rw, tbl[i].a, tbl[i].d, q, oe);
      if (tbl[i].rw) chk($sformatf("vec%0d read", i), q, tbl[i].exp);
      chk($sformatf("vec%0d nSD", i), {nSD1, nSD0}, tbl[i].expSd);
    end
    chk("idle DOE", DOE, 0);

    wr(2'd1, 8'h01);
    runXfer("A5@div0", 0, 8'hA5, 8'h3C);
    lastRx = 8'h3C;

    for (int i = 0; i < 6; i++) begin
      int         div = int'($urandom_range(0, 3));
      logic [7:0] tx  = 8'($urandom);
      logic [7:0] mi  = 8'($urandom);
      runXfer($sformatf("rnd%0d", i), div, tx, mi);
      lastRx = mi;
    end

    // Overrun: second start while busy is dropped and flagged.
    wr(2'd2, 8'd59);
    misoByte = 8'h81;
    clearRec();
    wr(2'd0, 8'h40);
    wr(2'd0, 8'h11);
    rd("data during busy", 2'd0, lastRx);
    rd("status ovr", 2'd1, 8'hC1);
    rd("status ovr cleared", 2'd1, 8'h81);
    waitIdle();
    checkXfer("40@div59", 59, 8'h40);
    rd("40 rx", 2'd0, 8'h81);
    rd("status idle", 2'd1, 8'h01);
    lastRx = 8'h81;

    // AUTO: reading DATA clocks out 0xFF.
    wr(2'd1, 8'h07);
    chk("auto nSD", {nSD1, nSD0}, 2'b10);
    wr(2'd2, 8'd1);
    misoByte = 8'h5A;
    clearRec();
    rd("auto data read", 2'd0, lastRx);
    waitIdle();
    checkXfer("auto", 1, 8'hFF);
    wr(2'd1, 8'h01);
    rd("auto rx", 2'd0, 8'h5A);

    // Reset in the middle of a transfer.
    wr(2'd2, 8'd3);
    misoByte = 8'h33;
    clearRec();
    wr(2'd0, 8'hC3);
    begin
      int n = 0;
      while (mosiQ.size() < 4 && n < 2000) begin
        @(negedge MHZ48);
        n++;
      end
      chk("reached bit 4", mosiQ.size() >= 4, 1);
    end
    @(negedge MHZ48);
    RES = 1'b1;
    #1;
    chk("abort SCLK", SCLK, 0);
    chk("abort MOSI", MOSI, 1);
    chk("abort nSD", {nSD1, nSD0}, 2'b11);
    chk("abort busy", dut.busy, 0);
    @(negedge MHZ48);
    RES = 1'b0;
    repeat (2) @(negedge MHZ48);
    rd("abort rx", 2'd0, 8'hFF);
    rd("abort div", 2'd2, 8'h3B);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
